// File: rtl/cb_filter_mp.sv
// Multi-port counting bloom filter with saturating buckets, backpressured inserts
// and a sticky under/overflow flag. Includes the shared seed package and hash block.

package cb_filter_pkg;
    localparam int unsigned SeedCnstWidth = 64;
    localparam int unsigned SeedRotWidth  = 6;

    typedef struct packed {
        logic [SeedCnstWidth-1:0] cnst;
        logic [SeedRotWidth-1:0]  rot;
    } cb_seed_t;

    localparam cb_seed_t [2:0] EgSeeds = {
        cb_seed_t'{cnst: 64'hA4093822299F31D0, rot: 6'd19},
        cb_seed_t'{cnst: 64'h13198A2E03707344, rot: 6'd13},
        cb_seed_t'{cnst: 64'h243F6A8885A308D3, rot: 6'd7}
    };

    localparam logic [63:0] HashMul = 64'h9E3779B97F4A7C15;
endpackage

// K-way hash to a one-hot-per-hash bucket indicator (xor/rotate/multiply, then xor-fold).
module hash_block #(
    parameter int unsigned KHashes    = 3,
    parameter int unsigned HashWidth  = 4,
    parameter int unsigned HashRounds = 1,
    parameter int unsigned InpWidth   = 32,
    parameter cb_filter_pkg::cb_seed_t [KHashes-1:0] Seeds = cb_filter_pkg::EgSeeds
) (
    input  logic [InpWidth-1:0]       data_i,
    output logic [2**HashWidth-1:0]   ind_o
);
    localparam int unsigned NFold = (InpWidth + HashWidth - 1) / HashWidth;
    localparam logic [InpWidth-1:0] Mul = InpWidth'(cb_filter_pkg::HashMul);

    always_comb begin
        logic [InpWidth-1:0]  w_x;
        logic [HashWidth-1:0] w_idx;
        int unsigned          w_sh;
        ind_o = '0;
        for (int k = 0; k < int'(KHashes); k++) begin
            w_x  = data_i;
            w_sh = 32'(Seeds[k].rot) % InpWidth;
            for (int r = 0; r < int'(HashRounds); r++) begin
                w_x = w_x ^ InpWidth'(Seeds[k].cnst);
                w_x = (w_x << w_sh) | (w_x >> ((InpWidth - w_sh) % InpWidth));
                w_x = InpWidth'(w_x * Mul);
            end
            w_idx = '0;
            for (int f = 0; f < int'(NFold); f++) begin
                w_idx = w_idx ^ HashWidth'(w_x >> (f * int'(HashWidth)));
            end
            ind_o[w_idx] = 1'b1;
        end
    end
endmodule

module cb_filter_mp
    import cb_filter_pkg::*;
#(
    parameter int unsigned KHashes     = 3,
    parameter int unsigned HashWidth   = 4,
    parameter int unsigned HashRounds  = 1,
    parameter int unsigned InpWidth    = 32,
    parameter int unsigned BucketWidth = 4,
    parameter int unsigned UsageWidth  = 8,
    parameter int unsigned NumLook     = 2,
    parameter int unsigned NumIncr     = 2,
    parameter int unsigned NumDecr     = 2,
    parameter cb_seed_t [KHashes-1:0] Seeds = EgSeeds
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumLook-1:0][InpWidth-1:0]   look_data_i,
    output logic [NumLook-1:0]                 look_valid_o,
    input  logic [NumIncr-1:0][InpWidth-1:0]   incr_data_i,
    input  logic [NumIncr-1:0]                 incr_valid_i,
    output logic [NumIncr-1:0]                 incr_ready_o,
    input  logic [NumDecr-1:0][InpWidth-1:0]   decr_data_i,
    input  logic [NumDecr-1:0]                 decr_valid_i,
    input  logic                               filter_clear_i,
    output logic [UsageWidth-1:0]              filter_usage_o,
    output logic                               filter_full_o,
    output logic                               filter_empty_o,
    output logic                               filter_error_o
);
    localparam int unsigned NBkt  = 2**HashWidth;
    localparam int unsigned DW    = $clog2(NumIncr + NumDecr + 1) + 1;
    localparam int unsigned BSW   = BucketWidth + DW + 1;
    localparam int unsigned USW   = UsageWidth + DW + 1;
    localparam int unsigned BMax  = 2**BucketWidth - 1;
    localparam int unsigned UMax  = 2**UsageWidth - 1;
    localparam logic [BucketWidth-1:0] BHigh = BucketWidth'(BMax - NumIncr);
    localparam logic [UsageWidth-1:0]  UHigh = UsageWidth'(UMax - NumIncr);

    logic [NBkt-1:0][BucketWidth-1:0] r_bkt;
    logic [UsageWidth-1:0]            r_usage;
    logic                             r_err;

    logic [NumLook-1:0][NBkt-1:0]     w_look_ind;
    logic [NumIncr-1:0][NBkt-1:0]     w_incr_ind;
    logic [NumDecr-1:0][NBkt-1:0]     w_decr_ind;
    logic [NBkt-1:0]                  w_nz;
    logic [NBkt-1:0]                  w_low;
    logic [NumIncr-1:0]               w_fire;
    logic [NBkt-1:0][BucketWidth-1:0] w_bkt_nxt;
    logic [UsageWidth-1:0]            w_usage_nxt;
    logic                             w_err_set;

    for (genvar l = 0; l < NumLook; l++) begin : g_look
        hash_block #(.KHashes(KHashes), .HashWidth(HashWidth), .HashRounds(HashRounds),
                     .InpWidth(InpWidth), .Seeds(Seeds))
            u_hash (.data_i(look_data_i[l]), .ind_o(w_look_ind[l]));
    end
    for (genvar p = 0; p < NumIncr; p++) begin : g_incr
        hash_block #(.KHashes(KHashes), .HashWidth(HashWidth), .HashRounds(HashRounds),
                     .InpWidth(InpWidth), .Seeds(Seeds))
            u_hash (.data_i(incr_data_i[p]), .ind_o(w_incr_ind[p]));
    end
    for (genvar q = 0; q < NumDecr; q++) begin : g_decr
        hash_block #(.KHashes(KHashes), .HashWidth(HashWidth), .HashRounds(HashRounds),
                     .InpWidth(InpWidth), .Seeds(Seeds))
            u_hash (.data_i(decr_data_i[q]), .ind_o(w_decr_ind[q]));
    end

    // Per-bucket status: nonzero for lookups, headroom for conservative ready
    always_comb begin
        for (int b = 0; b < int'(NBkt); b++) begin
            w_nz[b]  = (r_bkt[b] != '0);
            w_low[b] = (r_bkt[b] <= BHigh);
        end
    end

    always_comb begin
        for (int l = 0; l < int'(NumLook); l++) begin
            look_valid_o[l] = ((w_look_ind[l] & ~w_nz) == '0);
        end
        for (int p = 0; p < int'(NumIncr); p++) begin
            incr_ready_o[p] = !rst_i && !filter_clear_i && (r_usage <= UHigh)
                              && ((w_incr_ind[p] & ~w_low) == '0);
        end
    end

    assign w_fire = incr_valid_i & incr_ready_o;

    // Signed net delta per bucket and for usage, saturated into range
    always_comb begin
        logic signed [DW-1:0]  w_d;
        logic signed [BSW-1:0] w_nb;
        logic signed [USW-1:0] w_nu;
        w_bkt_nxt   = r_bkt;
        w_usage_nxt = r_usage;
        w_err_set   = 1'b0;
        for (int b = 0; b < int'(NBkt); b++) begin
            w_d = '0;
            for (int p = 0; p < int'(NumIncr); p++) begin
                if (w_fire[p] && w_incr_ind[p][b]) w_d = w_d + DW'(1);
            end
            for (int q = 0; q < int'(NumDecr); q++) begin
                if (decr_valid_i[q] && w_decr_ind[q][b]) w_d = w_d - DW'(1);
            end
            w_nb = $signed({{(BSW-BucketWidth){1'b0}}, r_bkt[b]})
                 + $signed({{(BSW-DW){w_d[DW-1]}}, w_d});
            if (w_nb < 0) begin
                w_bkt_nxt[b] = '0;
                w_err_set    = 1'b1;
            end else if (w_nb > $signed(BSW'(BMax))) begin
                w_bkt_nxt[b] = BucketWidth'(BMax);
                w_err_set    = 1'b1;
            end else begin
                w_bkt_nxt[b] = BucketWidth'(w_nb);
            end
        end
        w_d = '0;
        for (int p = 0; p < int'(NumIncr); p++) begin
            if (w_fire[p]) w_d = w_d + DW'(1);
        end
        for (int q = 0; q < int'(NumDecr); q++) begin
            if (decr_valid_i[q]) w_d = w_d - DW'(1);
        end
        w_nu = $signed({{(USW-UsageWidth){1'b0}}, r_usage})
             + $signed({{(USW-DW){w_d[DW-1]}}, w_d});
        if (w_nu < 0) begin
            w_usage_nxt = '0;
            w_err_set   = 1'b1;
        end else if (w_nu > $signed(USW'(UMax))) begin
            w_usage_nxt = UsageWidth'(UMax);
            w_err_set   = 1'b1;
        end else begin
            w_usage_nxt = UsageWidth'(w_nu);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || filter_clear_i) begin
            r_bkt   <= '0;
            r_usage <= '0;
            r_err   <= 1'b0;
        end else begin
            r_bkt   <= w_bkt_nxt;
            r_usage <= w_usage_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    assign filter_usage_o = r_usage;
    assign filter_full_o  = |(~w_low);
    assign filter_empty_o = (r_usage == '0) && !(|w_nz);
    assign filter_error_o = r_err;
endmodule

// File: tb/tb_cb_filter_mp.sv
// Randomized bench for cb_filter_mp against an item-level bucket-count model,
// plus directed scenarios with hand-derived expectations.

module tb_cb_filter_mp;
    localparam int NB   = 16;
    localparam int BMAX = 15;
    localparam int UMAX = 255;
    localparam int NI   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][31:0] look_data, incr_data, decr_data;
    logic [1:0]       look_valid, incr_valid, incr_ready, decr_valid;
    logic             clr;
    logic [7:0]       usage;
    logic             full, empty, error;

    always #5 clk = ~clk;

    cb_filter_mp dut (
        .clk_i(clk), .rst_i(rst),
        .look_data_i(look_data), .look_valid_o(look_valid),
        .incr_data_i(incr_data), .incr_valid_i(incr_valid), .incr_ready_o(incr_ready),
        .decr_data_i(decr_data), .decr_valid_i(decr_valid),
        .filter_clear_i(clr), .filter_usage_o(usage), .filter_full_o(full),
        .filter_empty_o(empty), .filter_error_o(error)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    int m_bkt [NB];
    int m_usage;
    bit m_err;
    int m_acc = 0;

    logic [31:0] seed_c [3] = '{32'h85A308D3, 32'h03707344, 32'h299F31D0};
    int          seed_r [3] = '{7, 13, 19};

    // Set of buckets an item maps to: mix each seed into the data, then xor-fold nibbles
    function automatic logic [15:0] ind_of(logic [31:0] d);
        logic [15:0] m;
        logic [31:0] x;
        int          idx;
        m = '0;
        for (int k = 0; k < 3; k++) begin
            x = d ^ seed_c[k];
            x = (x << seed_r[k]) | (x >> (32 - seed_r[k]));
            x = x * 32'h7F4A7C15;
            idx = 0;
            for (int i = 0; i < 8; i++) idx = idx ^ int'((x >> (4 * i)) & 32'hF);
            m[idx] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit m_look(logic [31:0] d);
        logic [15:0] s;
        s = ind_of(d);
        for (int b = 0; b < NB; b++) if (s[b] && m_bkt[b] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready(int p);
        logic [15:0] s;
        if (rst || clr) return 1'b0;
        if (m_usage > UMAX - NI) return 1'b0;
        s = ind_of(incr_data[p]);
        for (int b = 0; b < NB; b++) if (s[b] && m_bkt[b] > BMAX - NI) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int b = 0; b < NB; b++) if (m_bkt[b] > BMAX - NI) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_empty();
        if (m_usage != 0) return 1'b0;
        for (int b = 0; b < NB; b++) if (m_bkt[b] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each item adds/removes one count in each bucket it maps to
    always @(posedge clk) begin : model
        int          nb [NB];
        bit          f [2];
        int          d, nu, acc;
        bit          e;
        logic [15:0] si [2];
        logic [15:0] sd [2];
        if (rst || clr) begin
            for (int b = 0; b < NB; b++) nb[b] = 0;
            m_bkt   <= nb;
            m_usage <= 0;
            m_err   <= 1'b0;
        end else begin
            e = m_err;
            acc = 0;
            for (int p = 0; p < 2; p++) begin
                f[p]  = incr_valid[p] && m_ready(p);
                si[p] = ind_of(incr_data[p]);
                sd[p] = ind_of(decr_data[p]);
                if (f[p]) acc++;
            end
            for (int b = 0; b < NB; b++) begin
                d = 0;
                for (int p = 0; p < 2; p++) begin
                    if (f[p] && si[p][b]) d++;
                    if (decr_valid[p] && sd[p][b]) d--;
                end
                nb[b] = m_bkt[b] + d;
                if (nb[b] < 0) begin nb[b] = 0; e = 1'b1; end
                if (nb[b] > BMAX) begin nb[b] = BMAX; e = 1'b1; end
            end
            nu = m_usage + acc - int'(decr_valid[0]) - int'(decr_valid[1]);
            if (nu < 0) begin nu = 0; e = 1'b1; end
            if (nu > UMAX) begin nu = UMAX; e = 1'b1; end
            m_bkt   <= nb;
            m_usage <= nu;
            m_err   <= e;
            m_acc   <= m_acc + acc;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 2; l++) check("look_valid", 32'(look_valid[l]), 32'(m_look(look_data[l])));
            for (int p = 0; p < 2; p++) check("incr_ready", 32'(incr_ready[p]), 32'(m_ready(p)));
            check("usage", 32'(usage), 32'(m_usage));
            check("full",  32'(full),  32'(m_full()));
            check("empty", 32'(empty), 32'(m_empty()));
            check("error", 32'(error), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        incr_valid = '0;
        decr_valid = '0;
        clr        = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_usage"}, 32'(usage), 32'd0);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_look"},  32'(look_valid), 32'd0);
    endtask

    logic [31:0] pool [8];
    int          acc0;

    initial begin
        rst = 1'b1;
        look_data = '0; incr_data = '0; decr_data = '0;
        idle();
        tick();
        chk_en = 1;
        @(negedge clk);
        check_reset_vals("rst");
        check("rst_ready_low", 32'(incr_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_high", 32'(incr_ready), 32'd3);

        // Basic insert / remove
        look_data[0] = 32'hDEADBEEF;
        incr_data[0] = 32'hDEADBEEF; incr_valid = 2'b01;
        tick(); idle();
        @(negedge clk);
        check("ins_look", 32'(look_valid[0]), 32'd1);
        check("ins_usage", 32'(usage), 32'd1);
        check("ins_empty", 32'(empty), 32'd0);
        decr_data[0] = 32'hDEADBEEF; decr_valid = 2'b01;
        tick(); idle();
        @(negedge clk);
        check("rem_look", 32'(look_valid[0]), 32'd0);
        check("rem_usage", 32'(usage), 32'd0);
        check("rem_empty", 32'(empty), 32'd1);
        check("rem_error", 32'(error), 32'd0);

        // Concurrent ports, including a removal of a never-inserted item
        look_data[0] = 32'h1234; look_data[1] = 32'h5678;
        incr_data[0] = 32'h1234; incr_data[1] = 32'h1234; incr_valid = 2'b11;
        decr_data[0] = 32'h5678; decr_valid = 2'b01;
        tick(); idle();
        @(negedge clk);
        check("conc_usage", 32'(usage), 32'd1);
        check("conc_look", 32'(look_valid[0]), 32'd1);
        clr = 1'b1;
        tick(); idle();

        // Same item inserted and removed in one cycle nets to zero
        look_data[0] = 32'hA5A5A5A5;
        incr_data[0] = 32'hA5A5A5A5; incr_valid = 2'b01;
        tick();
        decr_data[0] = 32'hA5A5A5A5; decr_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("same_usage", 32'(usage), 32'd1);
            check("same_look", 32'(look_valid[0]), 32'd1);
            check("same_error", 32'(error), 32'd0);
        end
        idle(); clr = 1'b1;
        tick(); idle();

        // Backpressure: two ports pushing the same item until buckets reach 14
        acc0 = m_acc;
        incr_data[0] = 32'hCAFE0000; incr_data[1] = 32'hCAFE0000; incr_valid = 2'b11;
        look_data[0] = 32'hCAFE0000;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        check("bp_accepted", 32'(m_acc - acc0), 32'd14);
        check("bp_ready", 32'(incr_ready), 32'd0);
        check("bp_full", 32'(full), 32'd1);
        check("bp_usage", 32'(usage), 32'd14);
        check("bp_error", 32'(error), 32'd0);

        // Clear while traffic is offered
        clr = 1'b1;
        @(negedge clk);
        check("clr_ready", 32'(incr_ready), 32'd0);
        tick(); idle();
        @(negedge clk);
        check("clr_usage", 32'(usage), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_full", 32'(full), 32'd0);
        check("clr_error", 32'(error), 32'd0);

        // Reset pulse during back-to-back increments
        incr_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            incr_data[0] = $urandom; incr_data[1] = $urandom;
            tick();
        end
        rst = 1'b1;
        look_data[0] = incr_data[0]; look_data[1] = incr_data[1];
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        check_reset_vals("midrst");
        check("midrst_ready", 32'(incr_ready), 32'd3);

        // Randomized traffic over a small item pool
        for (int i = 0; i < 8; i++) pool[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 2; l++)
                look_data[l] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)];
            for (int p = 0; p < 2; p++) begin
                incr_data[p]  = pool[$urandom_range(0, 7)];
                decr_data[p]  = pool[$urandom_range(0, 7)];
                incr_valid[p] = ($urandom_range(0, 9) < 4);
                decr_valid[p] = ($urandom_range(0, 9) < 3);
            end
            clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; idle();
        tick();
        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
